// File: rtl/sp_mem_requester_if.sv
// Bundle of the tile-command, tile-return and arbiter scratchpad signals of sp_mem_requester.
// The master modport is the requester side and the slave modport is its environment.
interface sp_mem_requester_if #(parameter int ADDR_W = 32);
  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_op;
  logic [ADDR_W-1:0] cmd_addr;
  logic [255:0]      cmd_wdata;
  logic              tile_valid;
  logic              tile_ready;
  logic [255:0]      tile_data;
  logic              store_done;
  logic              err;
  logic              sLoad;
  logic [ADDR_W-1:0] load_addr;
  logic              sLoad_hit;
  logic [2:0]        sLoad_row;
  logic [63:0]       load_data;
  logic              sStore;
  logic [ADDR_W-1:0] store_addr;
  logic [63:0]       store_data;
  logic              sStore_hit;

  modport master (
    input  cmd_valid, cmd_op, cmd_addr, cmd_wdata, tile_ready,
    input  sLoad_hit, sLoad_row, load_data, sStore_hit,
    output cmd_ready, tile_valid, tile_data, store_done, err,
    output sLoad, load_addr, sStore, store_addr, store_data
  );

  modport slave (
    output cmd_valid, cmd_op, cmd_addr, cmd_wdata, tile_ready,
    output sLoad_hit, sLoad_row, load_data, sStore_hit,
    input  cmd_ready, tile_valid, tile_data, store_done, err,
    input  sLoad, load_addr, sStore, store_addr, store_data
  );
endinterface

// File: rtl/sp_mem_requester.sv
// Scratchpad-side initiator: moves one 4-row x 64-bit tile per command over sLoad/sStore.
// Optional watchdog enabled by defining SP_REQ_TIMEOUT_EN.
module sp_mem_requester #(
  parameter int ADDR_W         = 32,
  parameter int ROW_STRIDE     = 8,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input logic              CLK,
  input logic              nRST,
  sp_mem_requester_if.master bus
);
  typedef enum logic [2:0] {IDLE, LOAD, TILE_OUT, STORE, STORE_GAP} state_t;

  state_t            state, state_nx;
  logic [ADDR_W-1:0] base;
  logic [255:0]      wtile, tbuf;
  logic [3:0]        hit_mask, new_mask;
  logic [1:0]        row, row_nx;
  logic              store_q, done_q, err_q;
  logic [ADDR_W-1:0] saddr_q;
  logic [63:0]       sdata_q;
  logic              accept, load_hit, final_hit, store_hit, timeout;

  assign accept    = (state == IDLE) && bus.cmd_valid;
  assign load_hit  = (state == LOAD) && bus.sLoad_hit && !bus.sLoad_row[2];
  assign new_mask  = hit_mask | (load_hit ? (4'b0001 << bus.sLoad_row[1:0]) : 4'b0000);
  assign final_hit = load_hit && (&new_mask);
  assign store_hit = (state == STORE) && bus.sStore_hit;
  assign row_nx    = row + 2'd1;

`ifdef SP_REQ_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] cnt;
  logic          busy, any_hit;

  assign busy    = (state == LOAD) || (state == STORE);
  assign any_hit = ((state == LOAD) && bus.sLoad_hit) || store_hit;
  // Fires on the last permitted cycle so the state leaves exactly TIMEOUT_CYCLES cycles after entry.
  assign timeout = busy && !any_hit && (cnt == CW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST)                 cnt <= '0;
    else if (!busy || any_hit) cnt <= '0;
    else                       cnt <= cnt + 1'b1;
  end
`else
  assign timeout = 1'b0;
`endif

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:      if (accept) state_nx = bus.cmd_op ? STORE : LOAD;
      LOAD:      if (final_hit) state_nx = TILE_OUT;
                 else if (timeout) state_nx = IDLE;
      TILE_OUT:  if (bus.tile_ready) state_nx = IDLE;
      STORE:     if (store_hit) state_nx = (row == 2'd3) ? IDLE : STORE_GAP;
                 else if (timeout) state_nx = IDLE;
      STORE_GAP: state_nx = STORE;
      default:   state_nx = IDLE;
    endcase
  end

  // sLoad drops combinationally on the completing hit; the arbiter is already idle by then.
  always_comb begin
    bus.cmd_ready  = (state == IDLE);
    bus.tile_valid = (state == TILE_OUT);
    bus.sLoad      = (state == LOAD) && !final_hit;
  end

  assign bus.load_addr  = base;
  assign bus.tile_data  = tbuf;
  assign bus.sStore     = store_q;
  assign bus.store_addr = saddr_q;
  assign bus.store_data = sdata_q;
  assign bus.store_done = done_q;
  assign bus.err        = err_q;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      base     <= '0;
      wtile    <= '0;
      tbuf     <= '0;
      hit_mask <= '0;
      row      <= '0;
      store_q  <= 1'b0;
      saddr_q  <= '0;
      sdata_q  <= '0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      done_q <= store_hit && (row == 2'd3);
      if (timeout) begin
        err_q   <= 1'b1;
        store_q <= 1'b0;
      end
      if (accept) begin
        base     <= bus.cmd_addr;
        wtile    <= bus.cmd_wdata;
        hit_mask <= '0;
        row      <= '0;
        if (bus.cmd_op) begin
          store_q <= 1'b1;
          saddr_q <= bus.cmd_addr;
          sdata_q <= bus.cmd_wdata[63:0];
        end
      end
      if (load_hit) begin
        tbuf[{bus.sLoad_row[1:0], 6'b0} +: 64] <= bus.load_data;
        hit_mask <= new_mask;
      end
      // Next row's address/data load on the hit edge, ahead of the gap cycle.
      if (store_hit) begin
        store_q <= 1'b0;
        if (row != 2'd3) begin
          row     <= row_nx;
          saddr_q <= base + ADDR_W'(row_nx) * ADDR_W'(ROW_STRIDE);
          sdata_q <= wtile[{row_nx, 6'b0} +: 64];
        end
      end
      if (state == STORE_GAP) store_q <= 1'b1;
    end
  end
endmodule

// File: tb/tb_sp_mem_requester.sv
// Directed self-checking bench for sp_mem_requester; inputs driven and outputs sampled on the falling edge.
module tb_sp_mem_requester;
  logic CLK = 1'b0;
  logic nRST;
  int   errors = 0;
  int   checks = 0;

  always #5 CLK = ~CLK;

  sp_mem_requester_if #(.ADDR_W(32)) bus();

  sp_mem_requester #(.ADDR_W(32), .ROW_STRIDE(8), .TIMEOUT_CYCLES(16)) dut (
    .CLK(CLK), .nRST(nRST), .bus(bus)
  );

  task automatic idle_inputs();
    bus.cmd_valid  = 1'b0; bus.cmd_op = 1'b0; bus.cmd_addr = '0; bus.cmd_wdata = '0;
    bus.tile_ready = 1'b0; bus.sLoad_hit = 1'b0; bus.sLoad_row = '0; bus.load_data = '0;
    bus.sStore_hit = 1'b0;
  endtask

  task automatic test_reset();
    nRST = 1'b0;
    idle_inputs();
    #12;
    checks++; if (bus.cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_cmd_ready got=%b exp=1", bus.cmd_ready); end
    checks++; if ({bus.sLoad, bus.sStore, bus.tile_valid, bus.store_done, bus.err} !== 5'b0) begin
      errors++; $display("FAIL reset_flags got=%b exp=00000", {bus.sLoad, bus.sStore, bus.tile_valid, bus.store_done, bus.err}); end
    checks++; if (bus.tile_data !== 256'h0) begin errors++; $display("FAIL reset_tile_data got=%h exp=0", bus.tile_data); end
    checks++; if ({bus.load_addr, bus.store_addr, bus.store_data} !== 128'h0) begin
      errors++; $display("FAIL reset_addr_data got=%h/%h/%h exp=0", bus.load_addr, bus.store_addr, bus.store_data); end
    @(negedge CLK); nRST = 1'b1;
  endtask

  task automatic test_load();
    @(negedge CLK); bus.cmd_valid = 1'b1; bus.cmd_op = 1'b0; bus.cmd_addr = 32'h100;
    @(negedge CLK); bus.cmd_valid = 1'b0; #1;
    checks++; if (bus.sLoad !== 1'b1 || bus.load_addr !== 32'h100 || bus.cmd_ready !== 1'b0) begin
      errors++; $display("FAIL load_start got sLoad=%b addr=%h rdy=%b exp 1/100/0", bus.sLoad, bus.load_addr, bus.cmd_ready); end
    for (int r = 0; r < 4; r++) begin
      bus.sLoad_hit = 1'b1; bus.sLoad_row = 3'(r); bus.load_data = 64'hA0 + 64'(r); #1;
      checks++; if (bus.sLoad !== (r != 3)) begin errors++; $display("FAIL load_sload_row%0d got=%b exp=%b", r, bus.sLoad, r != 3); end
      @(negedge CLK);
    end
    bus.sLoad_hit = 1'b0; #1;
    checks++; if (bus.tile_data !== {64'hA3, 64'hA2, 64'hA1, 64'hA0}) begin errors++; $display("FAIL load_tile got=%h", bus.tile_data); end
    for (int k = 0; k < 3; k++) begin
      checks++; if (bus.tile_valid !== 1'b1 || bus.sLoad !== 1'b0) begin
        errors++; $display("FAIL load_tile_hold got valid=%b sLoad=%b exp 1/0", bus.tile_valid, bus.sLoad); end
      @(negedge CLK);
    end
    bus.tile_ready = 1'b1;
    @(negedge CLK); bus.tile_ready = 1'b0; #1;
    checks++; if (bus.tile_valid !== 1'b0 || bus.cmd_ready !== 1'b1) begin
      errors++; $display("FAIL load_release got valid=%b rdy=%b exp 0/1", bus.tile_valid, bus.cmd_ready); end
  endtask

  // Issues a store and walks all four rows; row r data is seed+r.
  task automatic test_store(input logic [31:0] base, input logic [63:0] seed);
    logic [31:0] ea;
    @(negedge CLK); bus.cmd_valid = 1'b1; bus.cmd_op = 1'b1; bus.cmd_addr = base;
    bus.cmd_wdata = {seed + 64'd3, seed + 64'd2, seed + 64'd1, seed};
    @(negedge CLK); bus.cmd_valid = 1'b0; #1;
    for (int r = 0; r < 4; r++) begin
      ea = base + 32'(8 * r);
      for (int w = 0; w < 2; w++) begin
        checks++; if (bus.sStore !== 1'b1 || bus.store_addr !== ea || bus.store_data !== seed + 64'(r)) begin
          errors++; $display("FAIL store_row%0d got s=%b a=%h d=%h exp 1/%h/%h", r, bus.sStore, bus.store_addr, bus.store_data, ea, seed + 64'(r)); end
        if (w == 0) begin @(negedge CLK); #1; end
      end
      bus.sStore_hit = 1'b1;
      @(negedge CLK); bus.sStore_hit = 1'b0; #1;
      if (r < 3) begin
        checks++; if (bus.sStore !== 1'b0 || bus.store_done !== 1'b0) begin
          errors++; $display("FAIL store_gap%0d got s=%b done=%b exp 0/0", r, bus.sStore, bus.store_done); end
        @(negedge CLK); #1;
      end else begin
        checks++; if (bus.store_done !== 1'b1 || bus.sStore !== 1'b0) begin
          errors++; $display("FAIL store_done got done=%b s=%b exp 1/0", bus.store_done, bus.sStore); end
        @(negedge CLK); #1;
        checks++; if (bus.store_done !== 1'b0 || bus.cmd_ready !== 1'b1) begin
          errors++; $display("FAIL store_done_pulse got done=%b rdy=%b exp 0/1", bus.store_done, bus.cmd_ready); end
      end
    end
  endtask

  task automatic test_out_of_order();
    logic [2:0]  rows  [6] = '{3'd2, 3'd0, 3'd5, 3'd0, 3'd3, 3'd1};
    logic [63:0] datas [6] = '{64'hB2, 64'hB0, 64'hFF, 64'hC0, 64'hB3, 64'hB1};
    @(negedge CLK); bus.cmd_valid = 1'b1; bus.cmd_op = 1'b0; bus.cmd_addr = 32'h180;
    @(negedge CLK); bus.cmd_valid = 1'b0;
    for (int i = 0; i < 6; i++) begin
      bus.sLoad_hit = 1'b1; bus.sLoad_row = rows[i]; bus.load_data = datas[i]; #1;
      checks++; if (bus.sLoad !== (i != 5)) begin errors++; $display("FAIL ooo_sload_hit%0d got=%b exp=%b", i, bus.sLoad, i != 5); end
      @(negedge CLK);
    end
    bus.sLoad_hit = 1'b0; #1;
    checks++; if (bus.tile_valid !== 1'b1 || bus.tile_data !== {64'hB3, 64'hB2, 64'hB1, 64'hC0}) begin
      errors++; $display("FAIL ooo_tile got valid=%b data=%h", bus.tile_valid, bus.tile_data); end
  endtask

  // Entered in TILE_OUT; queues a store at 0x400 behind the pending tile.
  task automatic test_back_to_back();
    @(negedge CLK); bus.cmd_valid = 1'b1; bus.cmd_op = 1'b1; bus.cmd_addr = 32'h400;
    bus.cmd_wdata = {64'hF3, 64'hF2, 64'hF1, 64'hF0};
    for (int k = 0; k < 10; k++) begin
      #1;
      checks++; if (bus.cmd_ready !== 1'b0 || bus.tile_valid !== 1'b1) begin
        errors++; $display("FAIL bp_cycle%0d got rdy=%b valid=%b exp 0/1", k, bus.cmd_ready, bus.tile_valid); end
      @(negedge CLK);
    end
    bus.tile_ready = 1'b1;
    @(negedge CLK); bus.tile_ready = 1'b0; #1;
    checks++; if (bus.cmd_ready !== 1'b1) begin errors++; $display("FAIL bp_idle got rdy=%b exp=1", bus.cmd_ready); end
    @(negedge CLK); bus.cmd_valid = 1'b0; #1;
    checks++; if (bus.cmd_ready !== 1'b0 || bus.sStore !== 1'b1 || bus.store_addr !== 32'h400) begin
      errors++; $display("FAIL bp_accept got rdy=%b s=%b a=%h exp 0/1/400", bus.cmd_ready, bus.sStore, bus.store_addr); end
  endtask

  // Continues the 0x400 store to row 2, then resets.
  task automatic test_reset_mid_store();
    int pulses = 0;
    for (int r = 0; r < 2; r++) begin
      bus.sStore_hit = 1'b1;
      @(negedge CLK); bus.sStore_hit = 1'b0;
      @(negedge CLK);
    end
    #1;
    checks++; if (bus.sStore !== 1'b1 || bus.store_addr !== 32'h410 || bus.store_data !== 64'hF2) begin
      errors++; $display("FAIL rst_row2 got s=%b a=%h d=%h exp 1/410/f2", bus.sStore, bus.store_addr, bus.store_data); end
    nRST = 1'b0; #1;
    checks++; if ({bus.sStore, bus.sLoad, bus.store_done, bus.tile_valid} !== 4'b0 || bus.store_addr !== 32'h0 ||
                  bus.store_data !== 64'h0 || bus.cmd_ready !== 1'b1) begin
      errors++; $display("FAIL rst_mid got s=%b a=%h d=%h rdy=%b exp 0/0/0/1", bus.sStore, bus.store_addr, bus.store_data, bus.cmd_ready); end
    @(negedge CLK); nRST = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge CLK);
      if (bus.store_done !== 1'b0 || bus.sStore !== 1'b0) pulses++;
    end
    checks++; if (pulses !== 0) begin errors++; $display("FAIL rst_no_done got=%0d active cycles exp=0", pulses); end
  endtask

`ifdef SP_REQ_TIMEOUT_EN
  task automatic test_timeout();
    @(negedge CLK); bus.cmd_valid = 1'b1; bus.cmd_op = 1'b0; bus.cmd_addr = 32'h600;
    @(negedge CLK); bus.cmd_valid = 1'b0;
    for (int k = 0; k < 16; k++) begin
      #1;
      checks++; if (bus.sLoad !== 1'b1 || bus.err !== 1'b0) begin
        errors++; $display("FAIL to_cycle%0d got sLoad=%b err=%b exp 1/0", k, bus.sLoad, bus.err); end
      @(negedge CLK);
    end
    for (int k = 0; k < 3; k++) begin
      #1;
      checks++; if (bus.sLoad !== 1'b0 || bus.err !== 1'b1 || bus.cmd_ready !== 1'b1 || bus.tile_valid !== 1'b0) begin
        errors++; $display("FAIL to_after%0d got sLoad=%b err=%b rdy=%b valid=%b exp 0/1/1/0", k, bus.sLoad, bus.err, bus.cmd_ready, bus.tile_valid); end
      @(negedge CLK);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_load();
    test_store(32'h200, 64'hD0);
    test_out_of_order();
    test_back_to_back();
    test_reset_mid_store();
    test_store(32'hFFFF_FFF0, 64'hE0);
    checks++; if (bus.err !== 1'b0) begin errors++; $display("FAIL err_idle got=%b exp=0", bus.err); end
`ifdef SP_REQ_TIMEOUT_EN
    test_timeout();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end
endmodule
